// File: rtl/acc_pkg.sv
// Shared constants, FSM state encoding and command-entry layout for the
// accelerator APB initiator.
package acc_pkg;

  localparam int APB_ADDR_W = 13;
  localparam int APB_DATA_W = 32;

  localparam logic [12:0] ACC_EN_ADDR     = 13'h1FFF;
  localparam logic [12:0] ACC_LOAD_A_ADDR = 13'd1;
  localparam logic [12:0] ACC_LOAD_X_ADDR = 13'd2;
  localparam logic [31:0] ACC_EN_VALUE    = 32'd1;
  localparam logic [31:0] ACC_END_VALUE   = 32'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Buffered command entry is {write, addr, wdata}.
  function automatic int cmd_entry_w(int addr_w);
    return 1 + addr_w + APB_DATA_W;
  endfunction

endpackage

// File: rtl/acc_apb_master_if.sv
// Host command/response stream plus APB bus of the accelerator initiator.
interface acc_apb_master_if #(
  parameter int ADDR_W = acc_pkg::APB_ADDR_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              busy;
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/acc_cmd_fifo.sv
// Two-entry register FIFO holding host commands ahead of the APB FSM.
module acc_cmd_fifo #(
  parameter int WIDTH = 46
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  // Caller guarantees push only when !full and pop only when !empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/acc_apb_master.sv
// APB initiator: buffers host commands and runs each as one SETUP->ACCESS
// transfer with wait-state support, timeout abort and one response per command.
//
// state     | meaning
// ST_IDLE   | bus idle, waiting for a buffered command
// ST_SETUP  | PSEL=1, PENABLE=0, address phase of the popped command
// ST_ACCESS | PSEL=1, PENABLE=1, waiting for PREADY or timeout
module acc_apb_master
  import acc_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 13,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TO_CNT_W       = 8
) (
  input logic               clk,
  input logic               rst,
  acc_apb_master_if.master  bus
);
  localparam int ENTRY_W = cmd_entry_w(APB_ADDR_WIDTH);

  apb_state_t                state;
  logic [TO_CNT_W-1:0]       to_cnt;
  logic                      psel, penable, pwrite;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [31:0]               pwdata;
  logic                      rsp_valid, rsp_err, rsp_timeout;
  logic [31:0]               rsp_rdata;

  logic [ENTRY_W-1:0]        push_data, head;
  logic                      full, empty, push, pop, to_hit;
  logic                      head_write;
  logic [APB_ADDR_WIDTH-1:0] head_addr;
  logic [31:0]               head_wdata;

  assign push_data  = {bus.cmd_write, bus.cmd_addr, bus.cmd_wdata};
  assign push       = bus.cmd_valid && !full;
  assign pop        = !empty && ((state == ST_IDLE) || (state == ST_ACCESS && bus.PREADY));
  assign head_write = head[ENTRY_W-1];
  assign head_addr  = head[32 +: APB_ADDR_WIDTH];
  assign head_wdata = head[31:0];
  // Counter saturates one short of the limit; the hit cycle is itself the last waited cycle.
  assign to_hit     = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

  acc_cmd_fifo #(.WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      to_cnt      <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            state  <= ST_SETUP;
            psel   <= 1'b1;
            paddr  <= head_addr;
            pwrite <= head_write;
            pwdata <= head_write ? head_wdata : 32'd0;
            to_cnt <= '0;
          end
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          penable <= 1'b1;
        end
        ST_ACCESS: begin
          if (bus.PREADY) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= pwrite ? 32'd0 : bus.PRDATA;
            rsp_err     <= bus.PSLVERR;
            rsp_timeout <= 1'b0;
            penable     <= 1'b0;
            if (!empty) begin
              state  <= ST_SETUP;
              paddr  <= head_addr;
              pwrite <= head_write;
              pwdata <= head_write ? head_wdata : 32'd0;
              to_cnt <= '0;
            end else begin
              state <= ST_IDLE;
              psel  <= 1'b0;
            end
          end else if (to_hit) begin
            rsp_valid   <= 1'b1;
            rsp_rdata   <= 32'd0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.busy        = (state != ST_IDLE) || !empty;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PWRITE      = pwrite;
  assign bus.PADDR       = paddr;
  assign bus.PWDATA      = pwdata;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.rsp_err     = rsp_err;
  assign bus.rsp_timeout = rsp_timeout;
endmodule

// File: tb/tb_acc_apb_master.sv
// Bench for acc_apb_master: transaction-level model of the command buffer,
// APB phases and responses, driven by directed and random command streams.
module tb_acc_apb_master;
  import acc_pkg::*;

  localparam int AW = 13;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_apb_master_if #(.ADDR_W(AW)) bus();

  acc_apb_master #(
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO),
    .TO_CNT_W       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // A command carries the slave behaviour the bench will apply to it.
  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            waits;
    logic          serr;
    logic [31:0]   rdata;
  } cmd_t;

  typedef enum {PH_IDLE, PH_SETUP, PH_ACCESS} ph_t;

  cmd_t        stim[$];
  cmd_t        pend[$];
  cmd_t        cur;
  ph_t         ph;
  int          acc_cnt;
  bit          rsp_due;
  logic [31:0] exp_rdata;
  logic        exp_err, exp_to;
  int          valid_pct;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cmd_t mk(logic w, logic [AW-1:0] a, logic [31:0] d,
                              int waits, logic serr, logic [31:0] rd);
    cmd_t c;
    c.w = w; c.addr = a; c.wdata = d; c.waits = waits; c.serr = serr; c.rdata = rd;
    return c;
  endfunction

  // One clock: compare what the DUT shows against the model, then choose the
  // slave and host inputs for the coming edge and advance the model.
  task automatic step();
    bit   ready_now;
    cmd_t nc;
    @(negedge clk);
    check("psel",    64'(bus.PSEL),    64'(ph != PH_IDLE));
    check("penable", 64'(bus.PENABLE), 64'(ph == PH_ACCESS));
    if (ph != PH_IDLE) begin
      check("paddr",  64'(bus.PADDR),  64'(cur.addr));
      check("pwrite", 64'(bus.PWRITE), 64'(cur.w));
      check("pwdata", 64'(bus.PWDATA), 64'(cur.w ? cur.wdata : 32'd0));
    end
    check("rsp_valid", 64'(bus.rsp_valid), 64'(rsp_due));
    if (rsp_due) begin
      check("rsp_rdata",   64'(bus.rsp_rdata),   64'(exp_rdata));
      check("rsp_err",     64'(bus.rsp_err),     64'(exp_err));
      check("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
    end
    ready_now = (pend.size() < 2);
    check("cmd_ready", 64'(bus.cmd_ready), 64'(ready_now));
    check("busy",      64'(bus.busy),      64'(ph != PH_IDLE || pend.size() != 0));

    rsp_due     = 1'b0;
    bus.PREADY  = 1'($urandom_range(0, 1));
    bus.PSLVERR = 1'($urandom_range(0, 1));
    bus.PRDATA  = $urandom;
    case (ph)
      PH_IDLE: begin
        if (pend.size() != 0) begin
          cur = pend.pop_front();
          ph  = PH_SETUP;
        end
      end
      PH_SETUP: begin
        ph      = PH_ACCESS;
        acc_cnt = 0;
      end
      PH_ACCESS: begin
        if (acc_cnt == cur.waits) begin
          bus.PREADY  = 1'b1;
          bus.PSLVERR = cur.serr;
          bus.PRDATA  = cur.rdata;
          rsp_due   = 1'b1;
          exp_rdata = cur.w ? 32'd0 : cur.rdata;
          exp_err   = cur.serr;
          exp_to    = 1'b0;
          if (pend.size() != 0) begin
            cur = pend.pop_front();
            ph  = PH_SETUP;
          end else begin
            ph = PH_IDLE;
          end
        end else begin
          bus.PREADY = 1'b0;
          acc_cnt++;
          if (acc_cnt == TO) begin
            rsp_due   = 1'b1;
            exp_rdata = 32'd0;
            exp_err   = 1'b1;
            exp_to    = 1'b1;
            ph        = PH_IDLE;
          end
        end
      end
      default: ph = PH_IDLE;
    endcase

    if (stim.size() != 0 && $urandom_range(0, 99) < valid_pct) begin
      nc = stim[0];
      bus.cmd_valid = 1'b1;
      bus.cmd_write = nc.w;
      bus.cmd_addr  = nc.addr;
      bus.cmd_wdata = nc.wdata;
      if (ready_now) begin
        pend.push_back(nc);
        stim.delete(0);
      end
    end else begin
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'($urandom_range(0, 1));
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_wdata = $urandom;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bit quiet;
    while ((stim.size() != 0 || pend.size() != 0 || ph != PH_IDLE || rsp_due) && n < 4000) begin
      step();
      n++;
    end
    quiet = (stim.size() == 0 && pend.size() == 0 && ph == PH_IDLE && !rsp_due);
    check(tag, 64'(quiet), 64'(1));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   r;
    int   waits;
    cmd_t c;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    ph            = PH_IDLE;
    rsp_due       = 1'b0;
    acc_cnt       = 0;
    valid_pct     = 100;

    repeat (2) @(negedge clk);
    check("rst_psel",      64'(bus.PSEL),        64'(0));
    check("rst_penable",   64'(bus.PENABLE),     64'(0));
    check("rst_cmd_ready", 64'(bus.cmd_ready),   64'(1));
    check("rst_busy",      64'(bus.busy),        64'(0));
    check("rst_rsp_valid", 64'(bus.rsp_valid),   64'(0));
    check("rst_rsp_err",   64'(bus.rsp_err),     64'(0));
    check("rst_rsp_to",    64'(bus.rsp_timeout), 64'(0));
    check("rst_rsp_rdata", 64'(bus.rsp_rdata),   64'(0));
    check("rst_paddr",     64'(bus.PADDR),       64'(0));
    check("rst_pwdata",    64'(bus.PWDATA),      64'(0));
    rst = 1'b0;

    // Single enable write, zero wait states.
    stim.push_back(mk(1'b1, ACC_EN_ADDR, ACC_EN_VALUE, 0, 1'b0, 32'h1234_5678));
    drain("drain_en_write");
    // Read with three wait states.
    stim.push_back(mk(1'b0, 13'd5, 32'hFFFF_FFFF, 3, 1'b0, 32'hDEAD_BEEF));
    drain("drain_wait_read");
    // Three back-to-back writes fill the buffer.
    stim.push_back(mk(1'b1, ACC_LOAD_A_ADDR, 32'h0000_0011, 0, 1'b0, 32'h0));
    stim.push_back(mk(1'b1, ACC_LOAD_A_ADDR, 32'h0000_0022, 0, 1'b0, 32'h0));
    stim.push_back(mk(1'b1, ACC_LOAD_X_ADDR, ACC_END_VALUE, 0, 1'b0, 32'h0));
    drain("drain_b2b");
    // Stuck slave times out, the queued read behind it still completes.
    stim.push_back(mk(1'b1, 13'h0AA, 32'hCAFE_0001, 40, 1'b0, 32'h0));
    stim.push_back(mk(1'b0, 13'h0AB, 32'h0, 1, 1'b0, 32'h0BAD_F00D));
    drain("drain_timeout");
    // Boundary: 15 waits completes, 16 waits aborts.
    stim.push_back(mk(1'b0, 13'h010, 32'h0, TO - 1, 1'b1, 32'h5555_AAAA));
    stim.push_back(mk(1'b0, 13'h011, 32'h0, TO, 1'b0, 32'h7777_7777));
    drain("drain_to_edge");
    // Slave error on a write.
    stim.push_back(mk(1'b1, 13'h123, 32'hA5A5_A5A5, 0, 1'b1, 32'h0));
    drain("drain_slverr");

    for (int i = 0; i < 200; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 14)      waits = int'($urandom_range(0, 3));
      else if (r < 19) waits = int'($urandom_range(TO - 2, TO + 1));
      else             waits = 40;
      c = mk(1'($urandom_range(0, 1)), AW'($urandom), $urandom, waits,
             1'($urandom_range(0, 3) == 0), $urandom);
      stim.push_back(c);
    end
    for (int blk = 0; blk < 4; blk++) begin
      valid_pct = (blk % 2 == 0) ? 100 : 40;
      n = 0;
      while (stim.size() > 150 - 50 * blk && n < 8000) begin
        step();
        n++;
      end
    end
    valid_pct = 100;
    drain("drain_random");

    // Reset during ACCESS with one command still queued.
    stim.push_back(mk(1'b0, 13'h040, 32'h0, 30, 1'b0, 32'h1111_2222));
    stim.push_back(mk(1'b1, 13'h041, 32'h3333_4444, 0, 1'b0, 32'h0));
    n = 0;
    while (!(ph == PH_ACCESS && pend.size() == 1) && n < 50) begin
      step();
      n++;
    end
    check("reach_access", 64'(ph == PH_ACCESS && pend.size() == 1), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_psel",      64'(bus.PSEL),      64'(0));
    check("mid_rst_penable",   64'(bus.PENABLE),   64'(0));
    check("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    check("mid_rst_busy",      64'(bus.busy),      64'(0));
    check("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    pend.delete();
    stim.delete();
    ph            = PH_IDLE;
    rsp_due       = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
